// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver: frame-synchronous shadow latch, leading-zero
// blanking, per-digit dp/blink, PWM brightness and selectable output polarity.
module seg_scan_mux #(
    parameter int DIGITS         = 4,
    parameter int DWELL          = 16,
    parameter int BLINK_FRAMES   = 32,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0,
    localparam int BW            = $clog2(DWELL) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic                blank_lz,
    input  logic [BW-1:0]       brightness,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   sel,
    output logic                frame_start
);

    localparam int DW = $clog2(DWELL);
    localparam int GW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0]     LAST_DWELL = DW'(DWELL - 1);
    localparam logic [GW-1:0]     LAST_DIGIT = GW'(DIGITS - 1);
    localparam logic [FW-1:0]     LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]        SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            4'hF:    g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [DW-1:0]       dwell_q, dwell_d;
    logic [GW-1:0]       digit_q, digit_d;
    logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                blink_q, blink_d;
    logic                frame_start_s;

    logic [4*DIGITS-1:0] bcd_sh_q;
    logic [DIGITS-1:0]   dp_sh_q;
    logic [DIGITS-1:0]   mask_sh_q;
    logic                lz_sh_q;
    logic [BW-1:0]       bright_sh_q;

    logic                s1_valid_q, s1_first_q, s1_blink_q;
    logic [GW-1:0]       s1_digit_q;
    logic [DW-1:0]       s1_dwell_q;

    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                fs_q, fs_d;

    logic                lz_run_s;
    logic [DIGITS-1:0]   blank_s;
    logic [DIGITS-1:0]   sel_one_s;
    logic [3:0]          cur_nib_s;
    logic                cur_dp_s, cur_blank_s, cur_mask_s, lit_s;

    assign frame_start_s = en && (digit_q == {GW{1'b0}}) && (dwell_q == {DW{1'b0}});

    // Position counters and blink frame counter; everything freezes while en is low.
    always_comb begin
        dwell_d     = dwell_q;
        digit_d     = digit_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (en) begin
            if (dwell_q == LAST_DWELL) begin
                dwell_d = {DW{1'b0}};
                if (digit_q == LAST_DIGIT) begin
                    digit_d = {GW{1'b0}};
                    if (frame_cnt_q == LAST_FRAME) begin
                        frame_cnt_d = {FW{1'b0}};
                        blink_d     = ~blink_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Counters, frame-start shadow capture and stage-1 position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q     <= {DW{1'b0}};
            digit_q     <= {GW{1'b0}};
            frame_cnt_q <= {FW{1'b0}};
            blink_q     <= 1'b0;
            bcd_sh_q    <= {(4*DIGITS){1'b0}};
            dp_sh_q     <= {DIGITS{1'b0}};
            mask_sh_q   <= {DIGITS{1'b0}};
            lz_sh_q     <= 1'b0;
            bright_sh_q <= {BW{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_blink_q  <= 1'b0;
            s1_digit_q  <= {GW{1'b0}};
            s1_dwell_q  <= {DW{1'b0}};
        end else begin
            dwell_q     <= dwell_d;
            digit_q     <= digit_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            if (frame_start_s) begin
                bcd_sh_q    <= bcd_in;
                dp_sh_q     <= dp_in;
                mask_sh_q   <= blink_mask;
                lz_sh_q     <= blank_lz;
                bright_sh_q <= brightness;
            end
            s1_valid_q  <= en;
            s1_first_q  <= frame_start_s;
            // Phase travels with the position so a frame never changes blink state mid-digit.
            s1_blink_q  <= blink_q;
            s1_digit_q  <= digit_q;
            s1_dwell_q  <= dwell_q;
        end
    end

    // Stage-2 decode: blanking chain from the top digit down, digit pick, dark gating, polarity.
    always_comb begin
        lz_run_s    = lz_sh_q;
        blank_s     = {DIGITS{1'b0}};
        sel_one_s   = {DIGITS{1'b0}};
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        cur_mask_s  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run_s = lz_run_s && (bcd_sh_q[4*i +: 4] == 4'h0) && !dp_sh_q[i];
            if (i == 0) begin
                blank_s[i] = 1'b0;
            end else begin
                blank_s[i] = lz_run_s;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (s1_digit_q == GW'(i)) begin
                sel_one_s[i] = 1'b1;
                cur_nib_s    = bcd_sh_q[4*i +: 4];
                cur_dp_s     = dp_sh_q[i];
                cur_blank_s  = blank_s[i];
                cur_mask_s   = mask_sh_q[i];
            end else begin
                sel_one_s[i] = 1'b0;
            end
        end
        lit_s = s1_valid_q && !cur_blank_s && !(s1_blink_q && cur_mask_s)
                && ({1'b0, s1_dwell_q} < bright_sh_q);
        if (lit_s) begin
            seg_d = {cur_dp_s, glyph(cur_nib_s)} ^ SEG_OFF;
            sel_d = sel_one_s ^ SEL_OFF;
        end else begin
            seg_d = SEG_OFF;
            sel_d = SEL_OFF;
        end
        fs_d = s1_first_q;
    end

    // Stage-2 output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            sel_q <= SEL_OFF;
            fs_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
            fs_q  <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign sel         = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: a 4-digit active-high instance and a 6-digit
// inverted-polarity instance sharing clock, reset and enable.
module tb_seg_scan_mux;

    logic        clk;
    logic        reset;
    logic        en;

    logic [15:0] bcd_a;
    logic [3:0]  dp_a, mask_a, sel_a;
    logic        lz_a, fs_a;
    logic [4:0]  bright_a;
    logic [7:0]  seg_a;

    logic [23:0] bcd_b;
    logic [5:0]  dp_b, mask_b, sel_b;
    logic        lz_b, fs_b;
    logic [4:0]  bright_b;
    logic [7:0]  seg_b;

    logic [6:0]  glyph_tb [0:15];
    int          checks;
    int          errors;

    seg_scan_mux #(.DIGITS(4), .DWELL(16), .BLINK_FRAMES(2),
                   .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .bcd_in(bcd_a), .dp_in(dp_a),
        .blink_mask(mask_a), .blank_lz(lz_a), .brightness(bright_a),
        .seg(seg_a), .sel(sel_a), .frame_start(fs_a));

    seg_scan_mux #(.DIGITS(6), .DWELL(16), .BLINK_FRAMES(2),
                   .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .bcd_in(bcd_b), .dp_in(dp_b),
        .blink_mask(mask_b), .blank_lz(lz_b), .brightness(bright_b),
        .seg(seg_b), .sel(sel_b), .frame_start(fs_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Reset for two edges, then release; the caller is then in cycle 0.
    task automatic restart();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int p, d, pb, db;
        logic [3:0] nib, e_sel;
        logic [5:0] e_sel_b;
        logic [7:0] e_seg, e_seg_b;
        logic       e_fs, e_fs_b;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (seg_a !== 8'h00 || sel_a !== 4'h0 || fs_a !== 1'b0 ||
                seg_b !== 8'hFF || sel_b !== 6'h3F || fs_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals seg_a=%h sel_a=%b fs_a=%b seg_b=%h sel_b=%b fs_b=%b (want 00 0000 0 ff 111111 0)",
                         seg_a, sel_a, fs_a, seg_b, sel_b, fs_b);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k >= 2) begin
                p = (k - 2) % 64;  d = p / 16;
                nib = bcd_a[4*d +: 4];
                e_sel = 4'(4'b0001 << d);  e_seg = {1'b0, glyph_tb[nib]};  e_fs = (p == 0);
                pb = (k - 2) % 96;  db = pb / 16;
                nib = bcd_b[4*db +: 4];
                e_sel_b = ~(6'(6'b000001 << db));  e_seg_b = ~{1'b0, glyph_tb[nib]};  e_fs_b = (pb == 0);
            end else begin
                e_sel = 4'h0;  e_seg = 8'h00;  e_fs = 1'b0;
                e_sel_b = 6'h3F;  e_seg_b = 8'hFF;  e_fs_b = 1'b0;
            end
            checks++;
            if (sel_a !== e_sel || seg_a !== e_seg || fs_a !== e_fs) begin
                errors++;
                $display("FAIL startup_a cyc=%0d sel=%b want %b seg=%h want %h fs=%b want %b",
                         k, sel_a, e_sel, seg_a, e_seg, fs_a, e_fs);
            end
            checks++;
            if (sel_b !== e_sel_b || seg_b !== e_seg_b || fs_b !== e_fs_b) begin
                errors++;
                $display("FAIL startup_b cyc=%0d sel=%b want %b seg=%h want %h fs=%b want %b",
                         k, sel_b, e_sel_b, seg_b, e_seg_b, fs_b, e_fs_b);
            end
        end
    endtask

    task automatic test_lz();
        logic [7:0] seg_tab [0:3];
        logic [3:0] sel_tab [0:3];
        int d;
        for (int pass = 0; pass < 2; pass++) begin
            bcd_a = 16'h0070;  lz_a = 1'b1;  bright_a = 5'd16;  mask_a = 4'h0;
            dp_a  = (pass == 0) ? 4'b0000 : 4'b0100;
            seg_tab[0] = 8'h3F;  sel_tab[0] = 4'b0001;
            seg_tab[1] = 8'h07;  sel_tab[1] = 4'b0010;
            seg_tab[2] = (pass == 0) ? 8'h00 : 8'hBF;
            sel_tab[2] = (pass == 0) ? 4'b0000 : 4'b0100;
            seg_tab[3] = 8'h00;  sel_tab[3] = 4'b0000;
            restart();
            for (int k = 1; k <= 65; k++) begin
                step();
                if (k >= 2) begin
                    d = (k - 2) / 16;
                    checks++;
                    if (sel_a !== sel_tab[d] || seg_a !== seg_tab[d]) begin
                        errors++;
                        $display("FAIL lz_blank pass=%0d cyc=%0d sel=%b want %b seg=%h want %h",
                                 pass, k, sel_a, sel_tab[d], seg_a, seg_tab[d]);
                    end
                end
            end
        end
        lz_a = 1'b0;  dp_a = 4'h0;
    endtask

    task automatic test_brightness();
        int p, d;
        int on_cnt [0:3];
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        bcd_a = 16'h1234;  bright_a = 5'd4;
        for (int i = 0; i < 4; i++) on_cnt[i] = 0;
        restart();
        for (int k = 1; k <= 65; k++) begin
            step();
            if (k >= 2) begin
                p = k - 2;  d = p / 16;
                if ((p % 16) < 4) begin
                    e_sel = 4'(4'b0001 << d);  e_seg = {1'b0, glyph_tb[bcd_a[4*d +: 4]]};
                end else begin
                    e_sel = 4'h0;  e_seg = 8'h00;
                end
                if (sel_a[d] === 1'b1) on_cnt[d]++;
                checks++;
                if (sel_a !== e_sel || seg_a !== e_seg) begin
                    errors++;
                    $display("FAIL pwm4 cyc=%0d sel=%b want %b seg=%h want %h", k, sel_a, e_sel, seg_a, e_seg);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (on_cnt[i] != 4) begin
                errors++;
                $display("FAIL pwm4_count digit=%0d on=%0d want 4", i, on_cnt[i]);
            end
        end
        bright_a = 5'd0;
        restart();
        for (int k = 1; k <= 66; k++) begin
            step();
            checks++;
            if (sel_a !== 4'h0 || seg_a !== 8'h00) begin
                errors++;
                $display("FAIL pwm0 cyc=%0d sel=%b seg=%h want 0000 00", k, sel_a, seg_a);
            end
        end
        bright_a = 5'd16;
    endtask

    task automatic test_shadow_hex();
        int p, d;
        logic [15:0] v;
        logic [3:0]  e_sel;
        logic [7:0]  e_seg;
        bcd_a = 16'h1234;
        restart();
        for (int k = 1; k <= 130; k++) begin
            step();
            if (k >= 2) begin
                p = (k - 2) % 64;  d = p / 16;
                v = (k < 66) ? 16'h1234 : 16'hABCD;
                e_sel = 4'(4'b0001 << d);  e_seg = {1'b0, glyph_tb[v[4*d +: 4]]};
                checks++;
                if (sel_a !== e_sel || seg_a !== e_seg) begin
                    errors++;
                    $display("FAIL shadow_hex cyc=%0d sel=%b want %b seg=%h want %h", k, sel_a, e_sel, seg_a, e_seg);
                end
            end
            if (k == 20) bcd_a = 16'hABCD;
        end
        bcd_a = 16'h1234;
    endtask

    task automatic test_blink();
        int p, d, f;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        bcd_a = 16'h1234;  mask_a = 4'b0001;
        restart();
        for (int k = 1; k <= 2 + 64*5; k++) begin
            step();
            if (k >= 2) begin
                p = (k - 2) % 64;  d = p / 16;  f = (k - 2) / 64;
                if (d == 0 && ((f / 2) % 2) == 1) begin
                    e_sel = 4'h0;  e_seg = 8'h00;
                end else begin
                    e_sel = 4'(4'b0001 << d);  e_seg = {1'b0, glyph_tb[bcd_a[4*d +: 4]]};
                end
                checks++;
                if (sel_a !== e_sel || seg_a !== e_seg) begin
                    errors++;
                    $display("FAIL blink cyc=%0d frame=%0d sel=%b want %b seg=%h want %h",
                             k, f, sel_a, e_sel, seg_a, e_seg);
                end
            end
        end
        mask_a = 4'h0;
    endtask

    task automatic test_en();
        int p, d;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        logic       e_fs;
        bcd_a = 16'h1234;
        restart();
        for (int k = 1; k <= 80; k++) begin
            step();
            if (k < 2 || (k >= 38 && k <= 47)) begin
                e_sel = 4'h0;  e_seg = 8'h00;  e_fs = 1'b0;
            end else begin
                p = (k < 38) ? (k - 2) : (k - 12);
                d = (p % 64) / 16;
                e_sel = 4'(4'b0001 << d);  e_seg = {1'b0, glyph_tb[bcd_a[4*d +: 4]]};
                e_fs = ((p % 64) == 0);
            end
            checks++;
            if (sel_a !== e_sel || seg_a !== e_seg || fs_a !== e_fs) begin
                errors++;
                $display("FAIL en_pause cyc=%0d sel=%b want %b seg=%h want %h fs=%b want %b",
                         k, sel_a, e_sel, seg_a, e_seg, fs_a, e_fs);
            end
            en = (k >= 36 && k <= 45) ? 1'b0 : 1'b1;
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        logic       e_fs;
        bcd_a = 16'h1234;
        restart();
        for (int k = 1; k <= 30; k++) step();
        reset = 1'b1;
        for (int k = 31; k <= 36; k++) begin
            step();
            if (k == 34) begin
                e_sel = 4'b0001;  e_seg = 8'h66;  e_fs = 1'b1;
            end else if (k >= 35) begin
                e_sel = 4'b0001;  e_seg = 8'h66;  e_fs = 1'b0;
            end else begin
                e_sel = 4'h0;  e_seg = 8'h00;  e_fs = 1'b0;
            end
            checks++;
            if (sel_a !== e_sel || seg_a !== e_seg || fs_a !== e_fs) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d sel=%b want %b seg=%h want %h fs=%b want %b",
                         k, sel_a, e_sel, seg_a, e_seg, fs_a, e_fs);
            end
            if (k == 32) reset = 1'b0;
        end
    endtask

    initial begin
        glyph_tb = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        en       = 1'b1;
        bcd_a    = 16'h1234;  dp_a = 4'h0;  mask_a = 4'h0;  lz_a = 1'b0;  bright_a = 5'd16;
        bcd_b    = 24'h561234; dp_b = 6'h0; mask_b = 6'h0;  lz_b = 1'b0;  bright_b = 5'd16;
        step();
        test_reset();
        test_lz();
        test_brightness();
        test_shadow_hex();
        test_blink();
        test_en();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
